// File: rtl/computer_move_generator_if.sv
`default_nettype none
// ============================================================================
//  Module   : computer_move_generator_if
//  Brief    : Board-state / computer-move bundle between the game FSM
//             (master) and the computer move generator (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface computer_move_generator_if;
  logic       start;
  logic [1:0] pos1;
  logic [1:0] pos2;
  logic [1:0] pos3;
  logic [1:0] pos4;
  logic [1:0] pos5;
  logic [1:0] pos6;
  logic [1:0] pos7;
  logic [1:0] pos8;
  logic [1:0] pos9;
  logic [3:0] computer_position;
  logic       pc;
  logic       busy;
  logic       no_move;

  // Game side: owns the board and the move request, consumes the move.
  modport master (
    output start, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
    input  computer_position, pc, busy, no_move
  );

  // Move generator side: reads the board, produces the move.
  modport slave (
    input  start, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
    output computer_position, pc, busy, no_move
  );
endinterface
`default_nettype wire

// File: rtl/computer_move_generator.sv
`default_nettype none
// ============================================================================
//  Module   : computer_move_generator
//  Brief    : Computer player. Snapshots the board on start, then scans one
//             line/entry per cycle: win, then block, then preference order.
//             The chosen cell is presented with a PC_HOLD-cycle pc strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module computer_move_generator #(
  parameter int PC_HOLD  = 4,
  parameter bit BLOCK_EN = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset,
  computer_move_generator_if.slave     bus
);

  localparam logic [2:0] c_st_idle       = 3'd0;
  localparam logic [2:0] c_st_win_scan   = 3'd1;
  localparam logic [2:0] c_st_block_scan = 3'd2;
  localparam logic [2:0] c_st_pref_scan  = 3'd3;
  localparam logic [2:0] c_st_drive      = 3'd4;

  localparam logic [1:0] c_empty    = 2'b00;
  localparam logic [1:0] c_player   = 2'b01;
  localparam logic [1:0] c_computer = 2'b10;

  localparam logic [3:0] c_hold_last = 4'(PC_HOLD - 1);
  localparam logic [3:0] c_line_last = 4'd7;
  localparam logic [3:0] c_pref_last = 4'd8;

  logic [2:0] r_state;
  logic [2:0] w_state_next;
  logic [3:0] r_idx;
  logic [3:0] r_hold;
  logic [1:0] r_board [9];
  logic [3:0] r_computer_position;
  logic       r_no_move;

  logic [3:0] w_cell_a;
  logic [3:0] w_cell_b;
  logic [3:0] w_cell_c;
  logic [1:0] w_val_a;
  logic [1:0] w_val_b;
  logic [1:0] w_val_c;
  logic [1:0] w_side;
  logic       w_match;
  logic [3:0] w_match_cell;
  logic [3:0] w_pref_cell;
  logic       w_pref_empty;
  logic       w_line_last;
  logic       w_pref_last;
  logic       w_hold_last;

  // Line table: the three cell indices of the line currently being scanned.
  always_comb begin
    w_cell_a = 4'd0;
    w_cell_b = 4'd1;
    w_cell_c = 4'd2;
    case (r_idx[2:0])
      3'd0: begin w_cell_a = 4'd0; w_cell_b = 4'd1; w_cell_c = 4'd2; end
      3'd1: begin w_cell_a = 4'd3; w_cell_b = 4'd4; w_cell_c = 4'd5; end
      3'd2: begin w_cell_a = 4'd6; w_cell_b = 4'd7; w_cell_c = 4'd8; end
      3'd3: begin w_cell_a = 4'd0; w_cell_b = 4'd3; w_cell_c = 4'd6; end
      3'd4: begin w_cell_a = 4'd1; w_cell_b = 4'd4; w_cell_c = 4'd7; end
      3'd5: begin w_cell_a = 4'd2; w_cell_b = 4'd5; w_cell_c = 4'd8; end
      3'd6: begin w_cell_a = 4'd0; w_cell_b = 4'd4; w_cell_c = 4'd8; end
      3'd7: begin w_cell_a = 4'd2; w_cell_b = 4'd4; w_cell_c = 4'd6; end
      default: begin w_cell_a = 4'd0; w_cell_b = 4'd1; w_cell_c = 4'd2; end
    endcase
  end

  // Line match: two cells owned by the scanned side plus one empty cell.
  always_comb begin
    w_val_a      = r_board[w_cell_a];
    w_val_b      = r_board[w_cell_b];
    w_val_c      = r_board[w_cell_c];
    w_side       = (r_state == c_st_block_scan) ? c_player : c_computer;
    w_match      = 1'b0;
    w_match_cell = w_cell_a;
    if (w_val_a == w_side && w_val_b == w_side && w_val_c == c_empty) begin
      w_match      = 1'b1;
      w_match_cell = w_cell_c;
    end else if (w_val_a == w_side && w_val_c == w_side && w_val_b == c_empty) begin
      w_match      = 1'b1;
      w_match_cell = w_cell_b;
    end else if (w_val_b == w_side && w_val_c == w_side && w_val_a == c_empty) begin
      w_match      = 1'b1;
      w_match_cell = w_cell_a;
    end
  end

  // Preference list: centre, corners, then edges.
  always_comb begin
    w_pref_cell = 4'd0;
    case (r_idx)
      4'd0:    w_pref_cell = 4'd4;
      4'd1:    w_pref_cell = 4'd0;
      4'd2:    w_pref_cell = 4'd2;
      4'd3:    w_pref_cell = 4'd6;
      4'd4:    w_pref_cell = 4'd8;
      4'd5:    w_pref_cell = 4'd1;
      4'd6:    w_pref_cell = 4'd3;
      4'd7:    w_pref_cell = 4'd5;
      4'd8:    w_pref_cell = 4'd7;
      default: w_pref_cell = 4'd0;
    endcase
    w_pref_empty = (r_board[w_pref_cell] == c_empty);
    w_line_last  = (r_idx == c_line_last);
    w_pref_last  = (r_idx == c_pref_last);
    w_hold_last  = (r_hold == c_hold_last);
  end

  // State register; reset aborts any move in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: win scan, optional block scan, preference scan, drive.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (bus.start) w_state_next = c_st_win_scan;
      end
      c_st_win_scan: begin
        if (w_match)          w_state_next = c_st_drive;
        else if (w_line_last) w_state_next = BLOCK_EN ? c_st_block_scan : c_st_pref_scan;
      end
      c_st_block_scan: begin
        if (w_match)          w_state_next = c_st_drive;
        else if (w_line_last) w_state_next = c_st_pref_scan;
      end
      c_st_pref_scan: begin
        if (w_pref_empty)     w_state_next = c_st_drive;
        else if (w_pref_last) w_state_next = c_st_idle;
      end
      c_st_drive: begin
        if (w_hold_last) w_state_next = c_st_idle;
      end
      default: w_state_next = c_st_idle;
    endcase
  end

  // Datapath: board snapshot, scan index, hold counter, chosen move, no_move.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx               <= 4'd0;
      r_hold              <= 4'd0;
      r_computer_position <= 4'd0;
      r_no_move           <= 1'b0;
      for (int i = 0; i < 9; i++) r_board[i] <= c_empty;
    end else begin
      r_no_move <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (bus.start) begin
            r_board[0] <= bus.pos1;
            r_board[1] <= bus.pos2;
            r_board[2] <= bus.pos3;
            r_board[3] <= bus.pos4;
            r_board[4] <= bus.pos5;
            r_board[5] <= bus.pos6;
            r_board[6] <= bus.pos7;
            r_board[7] <= bus.pos8;
            r_board[8] <= bus.pos9;
            r_idx      <= 4'd0;
          end
        end
        c_st_win_scan, c_st_block_scan: begin
          if (w_match) begin
            r_computer_position <= w_match_cell;
            r_hold              <= 4'd0;
          end else if (w_line_last) begin
            r_idx <= 4'd0;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        c_st_pref_scan: begin
          if (w_pref_empty) begin
            r_computer_position <= w_pref_cell;
            r_hold              <= 4'd0;
          end else if (w_pref_last) begin
            r_no_move <= 1'b1;
            r_idx     <= 4'd0;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        c_st_drive: begin
          r_hold <= w_hold_last ? 4'd0 : r_hold + 4'd1;
        end
        default: r_idx <= 4'd0;
      endcase
    end
  end

  // Outputs: pc marks DRIVE, busy marks any non-idle state.
  always_comb begin
    bus.pc                = (r_state == c_st_drive);
    bus.busy              = (r_state != c_st_idle);
    bus.computer_position = r_computer_position;
    bus.no_move           = r_no_move;
  end

endmodule
`default_nettype wire

// File: tb/tb_computer_move_generator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_computer_move_generator
//  Brief    : Table-driven bench for computer_move_generator, with a queue of
//             expected moves and hand-written reset / snapshot sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_computer_move_generator;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_a;
  logic        start_b;
  logic [17:0] board_drv;
  logic        sel;

  always #5 clock = ~clock;

  computer_move_generator_if bif_a ();
  computer_move_generator_if bif_b ();

  assign bif_a.start = start_a;
  assign bif_b.start = start_b;
  assign bif_a.pos1 = board_drv[1:0];   assign bif_b.pos1 = board_drv[1:0];
  assign bif_a.pos2 = board_drv[3:2];   assign bif_b.pos2 = board_drv[3:2];
  assign bif_a.pos3 = board_drv[5:4];   assign bif_b.pos3 = board_drv[5:4];
  assign bif_a.pos4 = board_drv[7:6];   assign bif_b.pos4 = board_drv[7:6];
  assign bif_a.pos5 = board_drv[9:8];   assign bif_b.pos5 = board_drv[9:8];
  assign bif_a.pos6 = board_drv[11:10]; assign bif_b.pos6 = board_drv[11:10];
  assign bif_a.pos7 = board_drv[13:12]; assign bif_b.pos7 = board_drv[13:12];
  assign bif_a.pos8 = board_drv[15:14]; assign bif_b.pos8 = board_drv[15:14];
  assign bif_a.pos9 = board_drv[17:16]; assign bif_b.pos9 = board_drv[17:16];

  computer_move_generator #(.PC_HOLD(4), .BLOCK_EN(1'b1)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bif_a.slave)
  );

  computer_move_generator #(.PC_HOLD(1), .BLOCK_EN(1'b0)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bif_b.slave)
  );

  logic       obs_pc;
  logic       obs_busy;
  logic       obs_nomove;
  logic [3:0] obs_pos;
  assign obs_pc     = sel ? bif_b.pc                : bif_a.pc;
  assign obs_busy   = sel ? bif_b.busy              : bif_a.busy;
  assign obs_nomove = sel ? bif_b.no_move           : bif_a.no_move;
  assign obs_pos    = sel ? bif_b.computer_position : bif_a.computer_position;

  typedef struct {
    string      name;
    bit         unit;
    string      board;
    logic [3:0] pos;
    int         lat;
    bit         nomove;
    int         width;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] pos;
    int         lat;
    bit         nomove;
    int         width;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Board string, cell 0 first: '.' empty, 'O' player, 'X' computer, '#' invalid.
  function automatic logic [17:0] brd(input string s);
    logic [17:0] b;
    byte         c;
    b = '0;
    for (int i = 0; i < 9; i++) begin
      c = s[i];
      case (c)
        "O":     b[2*i +: 2] = 2'b01;
        "X":     b[2*i +: 2] = 2'b10;
        "#":     b[2*i +: 2] = 2'b11;
        default: b[2*i +: 2] = 2'b00;
      endcase
    end
    return b;
  endfunction

  task automatic set_start(input bit unit, input logic v);
    if (unit) start_b = v;
    else      start_a = v;
  endtask

  task automatic run_move(input bit unit, input string bs, input logic [3:0] pos,
                          input int lat, input bit nomove, input int width,
                          input string name, input bit disturb);
    exp_t e;
    int   n;
    bit   found;
    int   w;
    int   bad;
    int   extra;
    sel = unit;
    @(negedge clock);
    board_drv = brd(bs);
    set_start(unit, 1'b1);
    sb.push_back('{name, pos, lat, nomove, width});
    @(posedge clock);               // E0
    @(negedge clock);
    set_start(unit, 1'b0);
    chk({name, " busy_after_start"}, int'(obs_busy), 1);
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      if (disturb && n == 3) begin
        board_drv[9:8] = 2'b01;
        set_start(unit, 1'b1);
      end
      if (disturb && n == 4) set_start(unit, 1'b0);
      @(posedge clock);
      n++;
      @(negedge clock);
      if (obs_pc || obs_nomove) found = 1'b1;
    end
    set_start(unit, 1'b0);
    e = sb.pop_front();
    chk({e.name, " result_seen"}, int'(found), 1);
    chk({e.name, " latency"}, n, e.lat);
    chk({e.name, " no_move"}, int'(obs_nomove), int'(e.nomove));
    chk({e.name, " position"}, int'(obs_pos), int'(e.pos));
    if (e.nomove) begin
      chk({e.name, " pc_on_no_move"}, int'(obs_pc), 0);
      chk({e.name, " busy_on_no_move"}, int'(obs_busy), 0);
      @(negedge clock);
      chk({e.name, " no_move_one_cycle"}, int'(obs_nomove), 0);
      chk({e.name, " position_kept"}, int'(obs_pos), int'(e.pos));
    end else begin
      w = 0;
      bad = 0;
      while (obs_pc && w < 20) begin
        w++;
        if (obs_pos != e.pos || obs_nomove) bad++;
        @(negedge clock);
      end
      chk({e.name, " pc_width"}, w, e.width);
      chk({e.name, " position_stable"}, bad, 0);
      chk({e.name, " busy_after_pc"}, int'(obs_busy), 0);
    end
    if (disturb) begin
      extra = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clock);
        if (obs_pc || obs_busy) extra++;
      end
      chk({e.name, " no_second_burst"}, extra, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    vecs[0] = '{"empty",          1'b0, ".........", 4'd4, 17, 1'b0, 4};
    vecs[1] = '{"win_over_block", 1'b0, "XX.OO....", 4'd2,  1, 1'b0, 4};
    vecs[2] = '{"block_L6",       1'b0, "O.X.O....", 4'd8, 15, 1'b0, 4};
    vecs[3] = '{"full_board",     1'b0, "XOXXOOOXX", 4'd8, 25, 1'b1, 0};
    vecs[4] = '{"invalid_cells",  1'b0, "##..#....", 4'd2, 19, 1'b0, 4};
    vecs[5] = '{"win_L7",         1'b0, "O.XOX....", 4'd6,  8, 1'b0, 4};
    vecs[6] = '{"block_L2",       1'b0, "OO#...O.O", 4'd7, 11, 1'b0, 4};
    vecs[7] = '{"pref_last",      1'b0, "#X##O#X.O", 4'd7, 25, 1'b0, 4};
    vecs[8] = '{"b_empty",        1'b1, ".........", 4'd4,  9, 1'b0, 1};
    vecs[9] = '{"b_no_block",     1'b1, "O.X.O....", 4'd6, 12, 1'b0, 1};

    reset     = 1'b1;
    start_a   = 1'b0;
    start_b   = 1'b0;
    board_drv = '0;
    sel       = 1'b0;
    #12;
    chk("reset pc",       int'(bif_a.pc), 0);
    chk("reset busy",     int'(bif_a.busy), 0);
    chk("reset no_move",  int'(bif_a.no_move), 0);
    chk("reset position", int'(bif_a.computer_position), 0);
    chk("reset b busy",   int'(bif_b.busy), 0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i])
      run_move(vecs[i].unit, vecs[i].board, vecs[i].pos, vecs[i].lat,
               vecs[i].nomove, vecs[i].width, vecs[i].name, 1'b0);

    // Board change and repeated start while busy must not disturb the move.
    run_move(1'b0, ".........", 4'd4, 17, 1'b0, 4, "snapshot", 1'b1);

    // Reset while driving pc.
    sel = 1'b0;
    @(negedge clock);
    board_drv = '0;
    start_a = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start_a = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      @(negedge clock);
      if (obs_pc) found = 1;
    end
    chk("rst_drive reached_drive", found, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_drive pc",       int'(obs_pc), 0);
    chk("rst_drive busy",     int'(obs_busy), 0);
    chk("rst_drive position", int'(obs_pos), 0);
    @(negedge clock);
    reset = 1'b0;

    // Reset during the win scan.
    @(negedge clock);
    start_a = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start_a = 1'b0;
    @(negedge clock);
    chk("rst_scan busy_before", int'(obs_busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_scan pc",       int'(obs_pc), 0);
    chk("rst_scan busy",     int'(obs_busy), 0);
    chk("rst_scan position", int'(obs_pos), 0);
    @(negedge clock);
    reset = 1'b0;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (obs_pc || obs_busy) found++;
    end
    chk("rst_scan no_late_pc", found, 0);

    run_move(1'b0, "XX.OO....", 4'd2, 1, 1'b0, 4, "after_reset", 1'b0);

    chk("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/computer_move_generator.md
Name: computer_move_generator

Overview:
- Drives the game's computer side. It reads the nine board-position codes and produces computer_position and the pc strobe that the game FSM consumes in its COMPUTER state.
- It is the opposite end of the board-state / computer-move interface. The game writes the board and reads moves; this block reads the board and writes moves.
- Move choice is sequential and priority-ordered: take a win, otherwise block the player, otherwise take the first empty cell in preference order.

Parameters:
- PC_HOLD, 4, number of cycles pc stays high in DRIVE (legal range 1..15).
- BLOCK_EN, 1, 1 = run the block scan; 0 = skip straight from WIN_SCAN to PREF_SCAN.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a move; sampled only in IDLE
- pos1..pos9  input  2 each  board cells; 00 empty, 01 player, 10 computer, 11 invalid (treated as occupied by neither side)
- computer_position  output  4  chosen cell index 0..8 (0 = pos1 ... 8 = pos9)
- pc  output  1  computer-play strobe, high for PC_HOLD cycles
- busy  output  1  high in every state except IDLE
- no_move  output  1  one-cycle pulse when the board has no empty cell

Behaviour:
- Reset (async, active-high): state IDLE, computer_position=0, pc=0, busy=0, no_move=0, all indices=0. Reset mid-operation aborts immediately; no pc pulse is produced afterwards.
- Board snapshot: on the edge where state=IDLE and start=1, latch pos1..pos9 into an internal board. Then set state=WIN_SCAN, idx=0. Board changes after this edge are ignored until the next start.
- start outside IDLE is ignored; no queuing.
- Line table, fixed order:
  - L0 (0,1,2), L1 (3,4,5), L2 (6,7,8)
  - L3 (0,3,6), L4 (1,4,7), L5 (2,5,8)
  - L6 (0,4,8), L7 (2,4,6)
- WIN_SCAN: one line evaluated per edge, line[idx].
  - Match = exactly two cells equal 10 and the third equals 00.
  - On match: computer_position is loaded with the empty cell, state goes to DRIVE.
  - Else idx++. After L7 with no match, go to BLOCK_SCAN with idx=0 (or PREF_SCAN with idx=0 if BLOCK_EN=0).
- BLOCK_SCAN: identical to WIN_SCAN, but a match is two cells equal 01 plus one cell 00. After L7 with no match, go to PREF_SCAN with idx=0.
- PREF_SCAN: one entry per edge from the preference list 4,0,2,6,8,1,3,5,7.
  - First entry whose cell is 00 is loaded into computer_position; state goes to DRIVE.
  - If all 9 entries are occupied, assert no_move for 1 cycle and return to IDLE; pc stays 0.
- DRIVE: pc=1 for exactly PC_HOLD cycles, computer_position stable throughout. A 4-bit hold counter then returns the state to IDLE with pc=0.
- computer_position keeps its last value in IDLE; it only changes when a move is chosen.
- Latency, measured in edges after the start-sampling edge E0:
  - WIN match at L_k: pc rises after edge E(k+1).
  - BLOCK match at L_k: pc rises after edge E(9+k).
  - PREF match at entry j: pc rises after edge E(17+j) (E(9+j) when BLOCK_EN=0).
  - Worst case (full board): no_move after E25.
- Priority:
  - Within a scan, the lowest line or list index wins.
  - A win always beats a block, even when both exist.
- Cells coded 11 never satisfy a win or block match and are never chosen.
- busy = (state != IDLE). busy deasserts on the same edge where pc falls or no_move pulses.

Test Plan:
- Empty board, start pulse: computer_position=4, pc rises after E17, pc high 4 cycles, busy low afterwards; no_move stays 0.
- pos1=10, pos2=10, pos3=00, pos4=01, pos5=01, pos6=00, rest 00: win beats block; computer_position=2, pc rises after E1.
- pos1=01, pos5=01, pos9=00, pos3=10, rest 00: no win; block on L6 gives computer_position=8, pc rises after E15.
- Full board, no line complete, start: no_move pulses after E25, pc never rises, computer_position keeps its prior value.
- Start at E0, then change pos5 from 00 to 01 during the scan: result still computer_position=4 (snapshot honoured). A second start during busy is ignored; exactly one pc burst occurs.
- Assert reset during DRIVE, then during WIN_SCAN: pc=0, busy=0, computer_position=0 asynchronously. The next start gives the normal result. Also repeat the empty-board case with PC_HOLD=1 and BLOCK_EN=0: pc is high for exactly 1 cycle, rising after E9.
